// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multi-word adder.
// Provides the adder word width and the controller state encoding.
package multiword_adder_seq_pkg;

    localparam int WORD_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multiword_adder_seq_sixbitadder.sv
// sixbitadder: 6-bit combinational adder with carry in/out.
// Ports: A, B (6b), CarryIn -> Sum (6b), CarryOut.
import multiword_adder_seq_pkg::*;

module sixbitadder (
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              CarryIn,
    output logic [WORD_W-1:0] Sum,
    output logic              CarryOut
);

    logic [WORD_W:0] total;

    assign total = {1'b0, A} + {1'b0, B}
                 + {{WORD_W{1'b0}}, CarryIn};

    assign Sum      = total[WORD_W-1:0];
    assign CarryOut = total[WORD_W];

endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: adds two WORDS*6-bit operands one word per clock.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_a/in_b/in_cin;
//        out_valid/out_ready/out_sum/out_cout; busy.
import multiword_adder_seq_pkg::*;

module multiword_adder_seq #(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W*WORDS-1:0] in_a,
    input  logic [WORD_W*WORDS-1:0] in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int N     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e            state;
    logic [IDX_W-1:0]  idx;
    logic [N-1:0]      aSh;
    logic [N-1:0]      bSh;
    logic              carry;
    logic [WORD_W-1:0] wordSum;
    logic              wordCout;

    sixbitadder uAdder (
        .A        (aSh[WORD_W-1:0]),
        .B        (bSh[WORD_W-1:0]),
        .CarryIn  (carry),
        .Sum      (wordSum),
        .CarryOut (wordCout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            aSh      <= '0;
            bSh      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        aSh     <= in_a;
                        bSh     <= in_b;
                        carry   <= in_cin;
                        idx     <= '0;
                        out_sum <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    // Word idx lands in its slot; operands shift so
                    // the next word is always at bit 0.
                    out_sum[int'(idx)*WORD_W +: WORD_W] <= wordSum;
                    carry <= wordCout;
                    aSh   <= aSh >> WORD_W;
                    bSh   <= bSh >> WORD_W;
                    if (idx == LAST_IDX) begin
                        out_cout <= wordCout;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq (WORDS=4): vector table, corner
// sequences and random transactions against an arithmetic model.
module tb_multiword_adder_seq;

    localparam int WORDS = 4;
    localparam int N     = 6 * WORDS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int compared;
    int mismatched;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] expSum;
        logic         expCout;
    } vec_t;

    vec_t vecs[6];

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, stall, handshake.
    task automatic runTxn(input string name, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic cin,
                          input logic [N-1:0] expSum, input logic expCout,
                          input int stall, input bit pulses);
        int lat;
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk({name, " ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        in_valid = 1'b0;
        in_a     = N'($urandom);
        in_b     = N'($urandom);
        in_cin   = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(WORDS));
        chk({name, " sum"}, 32'(out_sum), 32'(expSum));
        chk({name, " cout"}, 32'(out_cout), 32'(expCout));
        chk({name, " inReadyDone"}, 32'(in_ready), 32'd0);
        chk({name, " busyDone"}, 32'(busy), 32'd1);
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (pulses) begin
                in_valid = s[0];
                in_a     = N'($urandom);
                in_b     = N'($urandom);
            end
            tick();
            if (pulses) begin
                chk({name, " holdValid"}, 32'(out_valid), 32'd1);
                chk({name, " holdSum"}, 32'(out_sum), 32'(expSum));
                chk({name, " holdReady"}, 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " validDrop"}, 32'(out_valid), 32'd0);
        chk({name, " readyBack"}, 32'(in_ready), 32'd1);
        chk({name, " sumKept"}, 32'(out_sum), 32'(expSum));
    endtask

    initial begin
        logic [N:0] ref25;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic rc;
        int seen;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        out_ready  = 1'b0;

        vecs[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1};
        vecs[1] = '{24'h2B0A15, 24'h000000, 1'b1, 24'h2B0A16, 1'b0};
        vecs[2] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0};
        vecs[3] = '{24'h03F03F, 24'h000001, 1'b0, 24'h03F040, 1'b0};
        vecs[4] = '{24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1};
        vecs[5] = '{24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0};

        tick();
        tick();
        chk("rst outValid", 32'(out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst outSum", 32'(out_sum), 32'd0);
        chk("rst outCout", 32'(out_cout), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst inReady", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            runTxn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].cin, vecs[i].expSum, vecs[i].expCout, 0, 0);
        end

        runTxn("stall", 24'hFFFFFF, 24'hFFFFFF, 1'b1,
               24'hFFFFFF, 1'b1, 5, 1);

        in_valid = 1'b1;
        in_a     = 24'h123456;
        in_b     = 24'h654321;
        in_cin   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort outValid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort outSum", 32'(out_sum), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort noResult", 32'(seen), 32'd0);
        runTxn("afterAbort", 24'h000FFF, 24'h000001, 1'b0,
               24'h001000, 1'b0, 0, 0);

        for (int t = 0; t < 200; t++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            if (t % 17 == 0) ra = '1;
            if (t % 23 == 0) rb = N'(1);
            ref25 = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
            runTxn($sformatf("rnd%0d", t), ra, rb, rc, ref25[N-1:0],
                   ref25[N], int'($urandom_range(0, 3)), t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
